fc_neuron_sequencer: RTL

FC_NEURON_SEQUENCER -- requirements
Module: fc_neuron_sequencer

---
 rtl/fc_neuron_sequencer_pkg.sv | 18 +
 rtl/fc_neuron_sequencer_sat_shift.sv | 18 +
 rtl/fc_neuron_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fc_neuron_sequencer_pkg.sv
// Shared definitions for the fully-connected neuron sequencer and its 32-lane MAC unit.
package fc_neuron_sequencer_pkg;

  localparam int ELEM_WIDTH   = 8;
  localparam int LANES        = 32;
  localparam int VEC_WIDTH    = ELEM_WIDTH * LANES;
  localparam int RESULT_WIDTH = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_COLLECT,
    S_OUTPUT
  } state_t;

endpackage

// File: rtl/fc_neuron_sequencer_sat_shift.sv
// Right-shifts the accumulated sum and clamps it to the 8-bit output range.
import fc_neuron_sequencer_pkg::*;

module fc_sat_shift #(
  parameter int IN_WIDTH = 24,
  parameter int SHIFT    = 8
) (
  input  logic [IN_WIDTH-1:0]   value,
  output logic [ELEM_WIDTH-1:0] result
);

  logic [IN_WIDTH-1:0] shifted;

  assign shifted = value >> SHIFT;
  assign result  = (|shifted[IN_WIDTH-1:ELEM_WIDTH]) ? {ELEM_WIDTH{1'b1}}
                                                     : shifted[ELEM_WIDTH-1:0];

endmodule

// File: rtl/fc_neuron_sequencer.sv
// Sequences one neuron: streams 32-element chunks through an external MAC unit,
// accumulates the chunk sums with saturation and emits a quantised 8-bit result.
import fc_neuron_sequencer_pkg::*;

module fc_neuron_sequencer #(
  parameter int NUM_CHUNKS = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int SHIFT      = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VEC_WIDTH-1:0]    in_feature,
  input  logic [VEC_WIDTH-1:0]    in_weight,
  output logic                    acc_en,
  output logic [VEC_WIDTH-1:0]    acc_feature,
  output logic [VEC_WIDTH-1:0]    acc_weight,
  input  logic                    acc_done,
  input  logic [RESULT_WIDTH-1:0] acc_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ELEM_WIDTH-1:0]   out_data
);

  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    acc_next;
  logic [ACC_WIDTH:0]      sum_wide;
  logic [CNT_W-1:0]        chunk_cnt;
  logic [ELEM_WIDTH-1:0]   quant;

  // Extra carry bit detects overflow so the accumulator pins at all-ones.
  assign sum_wide = {1'b0, acc} + {{(ACC_WIDTH + 1 - RESULT_WIDTH){1'b0}}, acc_result};
  assign acc_next = sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];

  fc_sat_shift #(
    .IN_WIDTH (ACC_WIDTH),
    .SHIFT    (SHIFT)
  ) u_sat_shift (
    .value  (acc),
    .result (quant)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DRAIN only moves on once the unit has dropped acc_done, so a stale done
  // from the previous chunk can never be seen by the next request.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    in_ready   = 1'b0;
    acc_en     = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        acc_en = 1'b1;
        if (acc_done) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!acc_done) state_next = (chunk_cnt == LAST_CHUNK) ? S_COLLECT : S_LOAD;
      end
      S_COLLECT: begin
        state_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc         <= '0;
      chunk_cnt   <= '0;
      acc_feature <= '0;
      acc_weight  <= '0;
      out_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc       <= '0;
            chunk_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            acc_feature <= in_feature;
            acc_weight  <= in_weight;
          end
        end
        S_ISSUE: begin
          if (acc_done) acc <= acc_next;
        end
        S_DRAIN: begin
          if (!acc_done && (chunk_cnt != LAST_CHUNK)) chunk_cnt <= chunk_cnt + CNT_W'(1);
        end
        S_COLLECT: begin
          out_data <= quant;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
